// File: rtl/apb_pkg.sv
// Shared types for the APB request arbiter: FSM state encoding and protection field.
package apb_pkg;

    localparam int unsigned PROT_W = 3;

    typedef logic [PROT_W-1:0] prot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic            found;
    logic [IDXW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // last_grant itself is visited last (k == NREQ)
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDXW'((32'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NREQ requesters: round-robin accept, SETUP/ACCESS
// sequencing, one-cycle response pulse to the owner, and a watchdog on stalled ACCESS.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned addrWidth = 32,
    parameter int unsigned dataWidth = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0]                 req_write,
    input  logic [NREQ*addrWidth-1:0]       req_addr,
    input  logic [NREQ*dataWidth-1:0]       req_wdata,
    input  logic [NREQ*(dataWidth/8)-1:0]   req_strb,
    input  logic [NREQ*PROT_W-1:0]          req_prot,
    output logic [NREQ-1:0]                 rsp_valid,
    output logic [dataWidth-1:0]            rsp_rdata,
    output logic                            rsp_slverr,
    output logic                            pselx,
    output logic                            penable,
    output logic                            pwrite,
    output logic [addrWidth-1:0]            paddr,
    output logic [dataWidth-1:0]            pwdata,
    output logic [dataWidth/8-1:0]          pstrb,
    output logic [PROT_W-1:0]               pprot,
    input  logic                            pready,
    input  logic                            pslverr,
    input  logic [dataWidth-1:0]            prdata
);

    localparam int unsigned IDXW  = $clog2(NREQ);
    localparam int unsigned STRBW = dataWidth / 8;
    localparam int unsigned WDW   = $clog2(TIMEOUT);

    apb_state_t         state, state_n;
    logic [IDXW-1:0]    last_grant, last_grant_n;
    logic [WDW-1:0]     wdog, wdog_n;
    logic [NREQ-1:0]    grant;
    logic [IDXW-1:0]    grant_idx;

    logic                 pselx_n, penable_n, pwrite_n, rsp_slverr_n;
    logic [addrWidth-1:0] paddr_n;
    logic [dataWidth-1:0] pwdata_n, rsp_rdata_n;
    logic [STRBW-1:0]     pstrb_n;
    logic [PROT_W-1:0]    pprot_n;
    logic [NREQ-1:0]      rsp_valid_n;

    logic [addrWidth-1:0] addr_a  [NREQ];
    logic [dataWidth-1:0] wdata_a [NREQ];
    logic [STRBW-1:0]     strb_a  [NREQ];
    logic [PROT_W-1:0]    prot_a  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*addrWidth +: addrWidth];
        assign wdata_a[i] = req_wdata[i*dataWidth +: dataWidth];
        assign strb_a[i]  = req_strb[i*STRBW +: STRBW];
        assign prot_a[i]  = req_prot[i*PROT_W +: PROT_W];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Next-state, APB phase and response logic
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        wdog_n       = wdog;
        pselx_n      = pselx;
        penable_n    = penable;
        pwrite_n     = pwrite;
        paddr_n      = paddr;
        pwdata_n     = pwdata;
        pstrb_n      = pstrb;
        pprot_n      = pprot;
        rsp_valid_n  = '0;
        rsp_rdata_n  = rsp_rdata;
        rsp_slverr_n = rsp_slverr;
        req_ready    = '0;

        unique case (state)
            IDLE: begin
                if (|req_valid && !rst) begin
                    req_ready    = grant;
                    last_grant_n = grant_idx;
                    pwrite_n     = req_write[grant_idx];
                    paddr_n      = addr_a[grant_idx];
                    pwdata_n     = wdata_a[grant_idx];
                    pstrb_n      = req_write[grant_idx] ? strb_a[grant_idx] : '0;
                    pprot_n      = prot_a[grant_idx];
                    pselx_n      = 1'b1;
                    penable_n    = 1'b0;
                    state_n      = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                wdog_n    = '0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                // pready on the final watchdog cycle still wins over the abort
                if (pready) begin
                    rsp_valid_n  = NREQ'(1) << last_grant;
                    rsp_rdata_n  = pwrite ? '0 : prdata;
                    rsp_slverr_n = pslverr;
                    pselx_n      = 1'b0;
                    penable_n    = 1'b0;
                    state_n      = IDLE;
                end else if (wdog == WDW'(TIMEOUT - 1)) begin
                    rsp_valid_n  = NREQ'(1) << last_grant;
                    rsp_rdata_n  = '0;
                    rsp_slverr_n = 1'b1;
                    pselx_n      = 1'b0;
                    penable_n    = 1'b0;
                    state_n      = IDLE;
                end else begin
                    wdog_n = wdog + WDW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDXW'(NREQ - 1);
            wdog       <= '0;
            pselx      <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            wdog       <= wdog_n;
            pselx      <= pselx_n;
            penable    <= penable_n;
            pwrite     <= pwrite_n;
            paddr      <= paddr_n;
            pwdata     <= pwdata_n;
            pstrb      <= pstrb_n;
            pprot      <= pprot_n;
            rsp_valid  <= rsp_valid_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_slverr <= rsp_slverr_n;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: vector table of single transfers plus
// timeout, reset-mid-ACCESS and round-robin fairness sequences.
module tb_apb_req_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned TO   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_strb;
    logic [NREQ*3-1:0]    req_prot;
    logic [DW-1:0]        rsp_rdata, pwdata, prdata;
    logic                 rsp_slverr, pselx, penable, pwrite, pready, pslverr;
    logic [AW-1:0]        paddr;
    logic [SW-1:0]        pstrb;
    logic [2:0]           pprot;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_req_arbiter #(
        .NREQ(NREQ), .addrWidth(AW), .dataWidth(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    typedef struct {
        int unsigned rq;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int unsigned waits;
        logic        err;
        logic [31:0] prdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int unsigned rq, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        req_write[rq]          = wr;
        req_addr[rq*AW +: AW]  = addr;
        req_wdata[rq*DW +: DW] = wdata;
        req_strb[rq*SW +: SW]  = strb;
        req_prot[rq*3 +: 3]    = prot;
    endtask

    // One complete transfer from accept to response, checking every phase
    task automatic do_xfer(input vec_t v);
        logic [3:0] onehot;
        onehot = 4'(1) << v.rq;
        drive_cmd(v.rq, v.wr, v.addr, v.wdata, v.strb, v.prot);
        req_valid = onehot;
        #1;
        chk("accept_ready", 32'(req_ready), 32'(onehot));
        step();
        req_valid = '0;
        chk("setup_ctl", 32'({pselx, penable}), 32'(2'b10));
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
        chk("setup_pstrb", 32'(pstrb), 32'(v.exp_pstrb));
        chk("setup_pprot", 32'(pprot), 32'(v.prot));
        if (v.wr) chk("setup_pwdata", pwdata, v.wdata);
        step();
        for (int w = 0; w <= int'(v.waits); w++) begin
            pready  = (w == int'(v.waits));
            pslverr = pready ? v.err : 1'b1;
            prdata  = pready ? v.prdata : 32'h0BAD_0BAD;
            chk("access_ctl", 32'({pselx, penable}), 32'(2'b11));
            chk("access_paddr", paddr, v.addr);
            chk("access_pstrb", 32'(pstrb), 32'(v.exp_pstrb));
            chk("access_no_rsp", 32'(rsp_valid), 32'(0));
            step();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'(onehot));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_slverr", 32'(rsp_slverr), 32'(v.exp_err));
        chk("rsp_psel_low", 32'({pselx, penable}), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int          ng, cyc, last_cyc, idx;
        int          exp_order[5];
        vec_t        v;

        vecs[0] = '{rq:1, wr:1'b0, addr:32'h0000_0010, wdata:32'h1111_1111, strb:4'hF, prot:3'b000,
                    waits:0, err:1'b0, prdata:32'hDEAD_BEEF, exp_pstrb:4'h0,
                    exp_rdata:32'hDEAD_BEEF, exp_err:1'b0};
        vecs[1] = '{rq:0, wr:1'b1, addr:32'h0000_0020, wdata:32'hA5A5_0001, strb:4'h5, prot:3'b001,
                    waits:3, err:1'b0, prdata:32'h1234_5678, exp_pstrb:4'h5,
                    exp_rdata:32'h0, exp_err:1'b0};
        vecs[2] = '{rq:2, wr:1'b0, addr:32'h0000_0030, wdata:32'h0, strb:4'hF, prot:3'b000,
                    waits:1, err:1'b1, prdata:32'hCAFE_F00D, exp_pstrb:4'h0,
                    exp_rdata:32'hCAFE_F00D, exp_err:1'b1};
        vecs[3] = '{rq:3, wr:1'b1, addr:32'h0000_0044, wdata:32'h0BAD_F00D, strb:4'hF, prot:3'b010,
                    waits:0, err:1'b1, prdata:32'h7777_7777, exp_pstrb:4'hF,
                    exp_rdata:32'h0, exp_err:1'b1};
        // pready on the 16th ACCESS cycle: the watchdog boundary, still a normal completion
        vecs[4] = '{rq:1, wr:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, strb:4'hA, prot:3'b101,
                    waits:TO-1, err:1'b0, prdata:32'h0000_0001, exp_pstrb:4'h0,
                    exp_rdata:32'h0000_0001, exp_err:1'b0};
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req_valid = '1;
        req_write = '1;
        pready = 1'b0;
        pslverr = 1'b0;
        prdata = '0;
        for (int i = 0; i < int'(NREQ); i++)
            drive_cmd(i, 1'b1, 32'hBAD0_0000 + 32'(i), 32'hFEED_0000 + 32'(i), 4'hF, 3'b111);
        #12;
        chk("reset_req_ready", 32'(req_ready), 32'(0));
        chk("reset_ctl", 32'({pselx, penable, pwrite}), 32'(0));
        chk("reset_paddr", paddr, 32'(0));
        chk("reset_pwdata", pwdata, 32'(0));
        chk("reset_pstrb_pprot", 32'({pstrb, pprot}), 32'(0));
        chk("reset_rsp", 32'({rsp_valid, rsp_slverr}), 32'(0));
        chk("reset_rdata", rsp_rdata, 32'(0));
        req_valid = '0;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

        // Watchdog abort with pready held low
        drive_cmd(2, 1'b0, 32'h0000_0050, 32'h0, 4'hF, 3'b000);
        req_valid = 4'b0100;
        prdata = 32'hFFFF_FFFF;
        #1;
        chk("to_accept", 32'(req_ready), 32'(4'b0100));
        step();
        req_valid = '0;
        for (int c = 1; c <= int'(TO) + 1; c++) begin
            chk("to_psel_held", 32'(pselx), 32'(1));
            chk("to_no_rsp", 32'(rsp_valid), 32'(0));
            step();
        end
        chk("to_psel_drop", 32'({pselx, penable}), 32'(0));
        chk("to_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
        chk("to_rsp_slverr", 32'(rsp_slverr), 32'(1));
        chk("to_rsp_rdata", rsp_rdata, 32'(0));

        v = '{rq:3, wr:1'b0, addr:32'h0000_0060, wdata:32'h0, strb:4'h3, prot:3'b100,
              waits:0, err:1'b0, prdata:32'h600D_CAFE, exp_pstrb:4'h0,
              exp_rdata:32'h600D_CAFE, exp_err:1'b0};
        do_xfer(v);

        // Reset while in ACCESS
        drive_cmd(0, 1'b1, 32'h0000_0077, 32'h1122_3344, 4'hF, 3'b000);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        chk("rst_pre_access", 32'({pselx, penable}), 32'(2'b11));
        rst = 1'b1;
        #1;
        chk("rst_async_ctl", 32'({pselx, penable}), 32'(0));
        chk("rst_async_paddr", paddr, 32'(0));
        chk("rst_async_rsp", 32'(rsp_valid), 32'(0));
        step();
        pready = 1'b1;
        step();
        chk("rst_hold_rsp", 32'(rsp_valid), 32'(0));
        rst = 1'b0;

        // Round-robin fairness with every requester valid continuously
        for (int i = 0; i < int'(NREQ); i++)
            drive_cmd(i, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 4'h0, 3'b000);
        req_valid = '1;
        #1;
        ng = 0;
        cyc = 0;
        last_cyc = 0;
        while (ng < 5 && cyc < 40) begin
            if (req_ready != '0) begin
                idx = 0;
                for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) idx = i;
                chk("rr_onehot", 32'($countones(req_ready)), 32'(1));
                chk("rr_order", 32'(idx), 32'(exp_order[ng]));
                if (ng == 0) chk("rr_first_cycle", 32'(cyc), 32'(0));
                else chk("rr_interval", 32'(cyc - last_cyc), 32'(3));
                last_cyc = cyc;
                ng++;
            end else if (cyc < 3) begin
                chk("rr_no_stale_rsp", 32'(rsp_valid), 32'(0));
            end
            step();
            cyc++;
        end
        if (ng < 5) begin
            checks++;
            errors++;
            $display("FAIL rr_budget: got %0d grants expected 5", ng);
        end
        req_valid = '0;
        repeat (4) step();
        pready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
